// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream (count, payload, XOR checksum)
// and writes 16-bit words into instruction memory while holding the core in reset.
module prog_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned WL_W     = ADDR_W + 1;
  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_cpu_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [WL_W-1:0]     r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_count;
  logic [7:0]          r_chk;
  logic [7:0]          r_hold;

  logic                w_accept;
  logic [15:0]         w_count;
  logic [WL_W-1:0]     w_words_nxt;

  // Handshake qualifier and derived values for the current byte.
  assign w_accept    = in_valid & r_in_ready;
  assign w_count     = {r_hold, in_data};
  assign w_words_nxt = r_words + WL_W'(1);

  // Frame parser, memory write generation and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_chk       <= '0;
      r_hold      <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state    <= S_CNT_HI;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_words    <= '0;
            r_addr     <= '0;
            r_chk      <= '0;
            r_cpu_rst  <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        S_CNT_HI: begin
          if (w_accept) begin
            r_hold  <= in_data;
            r_chk   <= r_chk ^ in_data;
            r_state <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (w_accept) begin
            r_count <= w_count;
            r_chk   <= r_chk ^ in_data;
            if (17'(w_count) > LP_DEPTH) begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else if (w_count == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_hold  <= in_data;
            r_chk   <= r_chk ^ in_data;
            r_state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_chk       <= r_chk ^ in_data;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= {r_hold, in_data};
            r_words     <= w_words_nxt;
            // Last word leaves the address parked so it never passes DEPTH-1.
            if (16'(w_words_nxt) == r_count) begin
              r_state <= S_CHECK;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_DATA_HI;
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            if (in_data == r_chk) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model, per-cycle write checker,
// directed frames with hand-computed expectations.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  logic [7:0] model_chk;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a frame must produce, computed from the frame format alone.
  task automatic model(input bq_t f, output int nb, output bit ok, output int words);
    int   n;
    logic [7:0] c;
    wr_t  w;
    n = int'({f[0], f[1]});
    c = 8'h00;
    if (n > int'(DEPTH)) begin
      nb = 2; ok = 1'b0; words = 0; model_chk = 8'h00;
      return;
    end
    for (int i = 0; i < 2 + 2 * n; i++) c = c ^ f[i];
    for (int k = 0; k < n; k++) begin
      w.addr = k;
      w.data = {f[2 + 2 * k], f[3 + 2 * k]};
      exp_q.push_back(w);
    end
    model_chk = c;
    nb    = 3 + 2 * n;
    ok    = (f[2 + 2 * n] == c);
    words = n;
  endtask

  // Every cycle: each write must be the next one the model predicts.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
      end else begin
        check("wr_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        check("wr_data", 32'(mem_wdata), 32'(exp_q[0].data));
        check("wr_held", {30'd0, busy, cpu_rst}, 32'h2);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    for (int t = 0; t < 40 && !acc; t++) begin
      acc = in_ready;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL byte_timeout: byte 0x%0h not accepted, required acceptance", b);
    end
  endtask

  // Start a load, stream the bytes the model says are consumed, check status.
  task automatic run_load(input string name, input bq_t f, input int gapmax, input int start_idx);
    int nb, words;
    bit ok;
    model(f, nb, ok, words);
    pulse_start();
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_held"}, 32'(cpu_rst), 32'd0);
    for (int i = 0; i < nb; i++)
      send_byte(f[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, (i == start_idx));
    check({name, "_done"}, 32'(done), 32'(ok));
    check({name, "_error"}, 32'(error), 32'(!ok));
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(ok));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_ready_end"}, 32'(in_ready), 32'd0);
    check({name, "_words"}, 32'(words_loaded), 32'(words));
    tick();
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
    check({name, "_we"}, 32'(mem_we), 32'd0);
    check({name, "_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_flags"}, {28'd0, cpu_rst, busy, done, error}, 32'd0);
    check({name, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    bq_t f, frand;
    int  nb, words;
    bit  ok;
    rst = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (2) tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);

    // Pin the model against hand-computed values.
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    model(f, nb, ok, words);
    check("pin_chk", 32'(model_chk), 32'h42);
    check("pin_nb", 32'(nb), 32'd7);
    check("pin_w0", 32'(exp_q[0].data), 32'h1234);
    check("pin_w1", 32'(exp_q[1].data), 32'hABCD);
    exp_q.delete();

    run_load("good", f, 0, -1);
    check("good_words_lit", 32'(words_loaded), 32'd2);

    f[6] = 8'h43;
    run_load("badchk", f, 0, -1);
    check("badchk_err_lit", {30'd0, done, error}, 32'd1);

    f = '{8'h04, 8'h01, 8'h00, 8'h00};
    run_load("oversize", f, 0, -1);
    repeat (3) tick();
    check("oversize_we", 32'(mem_we), 32'd0);

    f = '{8'h00, 8'h00, 8'h00};
    run_load("empty", f, 0, -1);
    check("empty_cpu_rst_lit", 32'(cpu_rst), 32'd1);

    // Gapped stream with a stray start mid-payload.
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_load("gaps", f, 3, 4);

    frand = '{8'h00, 8'h05};
    for (int i = 0; i < 10; i++) frand.push_back(8'($urandom));
    begin
      logic [7:0] c;
      c = 8'h00;
      foreach (frand[i]) c = c ^ frand[i];
      frand.push_back(c);
    end
    run_load("rand5", frand, 2, 7);

    // Abort after three payload bytes: one write issued, then async reset.
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    model(f, nb, ok, words);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(f[i], 0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check_reset_vals("abort");
    check("abort_writes_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    run_load("reload", f, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that fills the calculator core's instruction memory from a host link. It parses a framed stream (word count, payload, checksum) and issues one write per 16-bit instruction word.
- Holds the core in reset while a load is in progress. Releases the core only after a complete, checksum-valid load.
- Sits between the host link (UART or bench driver, valid/ready byte interface) and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory address width.
- DEPTH, 1024, instruction memory size in words. Must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte. A byte transfers when in_valid and in_ready are both high on a clk edge.
- mem_we  out  1  instruction memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- cpu_rst  out  1  active-low reset to the core; 0 holds the core.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky.
- error  out  1  last load failed; sticky.
- words_loaded  out  ADDR_W+1  words written in the current/last load.

Behaviour:
- Frame format, bytes in order:
  - CNT_H, CNT_L: 16-bit word count N, MSB first.
  - N words, each as HI then LO byte.
  - CHK: XOR of every preceding byte in the frame.
- Reset (async, rst=0) values:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst=0, busy=0, done=0, error=0, words_loaded=0.
  - Internal count, checksum and byte-holding registers cleared.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → CNT_HI on the next edge. On that edge:
  - clear done, error, words_loaded, address counter, checksum.
  - drive cpu_rst=0 and busy=1.
- in_ready=1 only in CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK. Every accepted byte XORs into the running checksum, except the CHK byte itself.
- CNT_HI: latch the high byte → CNT_LO.
- CNT_LO: form N, then:
  - N > DEPTH → ERROR.
  - N = 0 → CHECK.
  - otherwise → DATA_HI.
- DATA_HI: latch the high byte → DATA_LO.
- DATA_LO, on accept: on the next edge assert mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = {hi, lo}. Increment the address counter and words_loaded. Then:
  - words_loaded reaches N → CHECK.
  - otherwise → DATA_HI.
- Write latency: mem_we is high in the cycle after the LO byte handshake. in_ready stays high, so back-to-back bytes every cycle are legal.
- CHECK: compare the accepted byte with the running checksum.
  - Equal → DONE: done=1, busy=0, cpu_rst=1 from the next edge.
  - Mismatch → ERROR: error=1, busy=0, cpu_rst stays 0.
- The address counter never exceeds DEPTH-1; the N>DEPTH check guarantees no wrap.
- start while busy is ignored. Bytes arriving while in_ready=0 are not consumed.
- in_valid low in any receiving state: hold state, no timeout.
- Reset mid-load: immediate return to reset values. The core stays held and partially written memory is left as is.
- A new start after DONE asserts cpu_rst=0 again, so the core is re-held for the reload.

Test Plan:
- Reset, then start. Stream 00 02 12 34 AB CD 42 → mem_we pulses:
  - addr 0 with 0x1234.
  - addr 1 with 0xABCD.
  - then done=1, error=0, words_loaded=2, cpu_rst=1, busy=0.
- Same frame with CHK=0x43 → error=1, done=0, cpu_rst=0. Both writes were still issued.
- Count 0x0401 with DEPTH=1024 → ERROR right after CNT_L. No mem_we, in_ready=0 afterwards.
- Frame 00 00 00 (N=0, CHK=0) → done=1, no writes, cpu_rst=1.
- Random in_valid gaps plus a start pulse mid-load → data and addresses identical to the gap-free run, and the extra start is ignored.
- Assert rst low after 3 payload bytes → all outputs at reset values asynchronously. A following full valid load succeeds from address 0.
